// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: multi-cycle W-bit add/subtract built from one 4-bit
// add/sub slice. It processes one nibble per cycle, starting with the least
// significant nibble, and chains the carry through a register.
// Optional feature macro: NIBBLE_SERIAL_ALU_SAT_EN. When defined, a result that
// overflows is clamped to the signed limit.
//
// Handshake: start is accepted only in IDLE or DONE. busy is high exactly
// while nibbles are processed (RUN). done is a one-cycle pulse (DONE). result
// and the flags are valid from done onwards and hold until the next DONE entry.

module add_sub_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ctrl,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] b_int;

    // 4-bit add with optional B inversion (ctrl=1); carry-in supplied externally
    always_comb begin
        b_int       = ctrl ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_int} + {4'b0000, cin};
    end
endmodule

module nibble_serial_alu_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow,
    output logic                   zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_eff_q;   // B already inverted for subtraction
    logic [W-1:0]  shadow;    // result nibbles assembled so far
    logic [IW-1:0] idx;
    logic          carry;

    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [3:0]    slice_sum;
    logic          slice_cout;
    logic [W-1:0]  res_next;
    logic          ovf_next;
    logic [W-1:0]  res_final;
    logic          accept;

    // Select the current nibble of each latched operand for the shared slice
    always_comb begin
        slice_a = a_q[idx*4 +: 4];
        slice_b = b_eff_q[idx*4 +: 4];
    end

    add_sub_4b u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .ctrl (1'b0),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Merge this cycle's nibble into the shadow and derive final flags/clamp
    always_comb begin
        res_next                = shadow;
        res_next[idx*4 +: 4]    = slice_sum;
        ovf_next  = (a_q[W-1] == b_eff_q[W-1]) && (res_next[W-1] != a_q[W-1]);
        res_final = res_next;
`ifdef NIBBLE_SERIAL_ALU_SAT_EN
        if (ovf_next) begin
            res_final = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Sequencer: latch operands on accept, walk nibbles in RUN, publish on last
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_eff_q  <= '0;
            shadow   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_eff_q <= op_sub ? ~b : b;
                        carry   <= op_sub;
                        idx     <= '0;
                        shadow  <= '0;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    shadow <= res_next;
                    carry  <= slice_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        result   <= res_final;
                        cout     <= slice_cout;
                        overflow <= ovf_next;
                        zero     <= (res_final == '0);
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Testbench for nibble_serial_alu_ctrl (NIBBLES=4). The reference model works
// on whole words with plain arithmetic. Build with +define+NIBBLE_SERIAL_ALU_SAT_EN
// to check the saturating variant.

module tb_nibble_serial_alu_ctrl;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hold_res;
    logic         hold_c;
    logic         hold_ov;
    logic         hold_z;

    nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-word reference model
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic msub, output logic [W-1:0] r,
                                  output logic c, output logic v, output logic z);
        logic [W-1:0] be;
        logic [W:0]   s;
        be = msub ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, msub};
        r  = s[W-1:0];
        c  = s[W];
        v  = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
`ifdef NIBBLE_SERIAL_ALU_SAT_EN
        if (v) r = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        z  = (r == '0);
    endfunction

    // Present a request in the current cycle; returns in cycle 1 with the
    // input bus scrambled so late input changes are exercised.
    task automatic drive_start(input logic [W-1:0] da, input logic [W-1:0] db, input logic dsub);
        a = da; b = db; op_sub = dsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    endtask

    // Called in cycle 1 of an operation; checks RUN cycles and the DONE cycle.
    // poke>0 pulses an extra start during that RUN cycle.
    task automatic check_run(input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic esub, input int poke);
        logic [W-1:0] r;
        logic c, v, z;
        model(ea, eb, esub, r, c, v, z);
        for (int i = 1; i <= NIBBLES; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL run_busy cycle %0d: busy=%b done=%b, required busy=1 done=0", i, busy, done);
            end
            checks++;
            if (result !== hold_res || cout !== hold_c || overflow !== hold_ov || zero !== hold_z) begin
                errors++;
                $display("FAIL run_hold cycle %0d: result=%h c=%b v=%b z=%b, required %h %b %b %b",
                         i, result, cout, overflow, zero, hold_res, hold_c, hold_ov, hold_z);
            end
            if (i == poke) begin
                start = 1'b1; a = 16'hAAAA; b = W'($urandom); op_sub = 1'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        checks++;
        if (result !== r) begin
            errors++;
            $display("FAIL result a=%h b=%h sub=%b: got %h, required %h", ea, eb, esub, result, r);
        end
        checks++;
        if (cout !== c) begin
            errors++;
            $display("FAIL cout a=%h b=%h sub=%b: got %b, required %b", ea, eb, esub, cout, c);
        end
        checks++;
        if (overflow !== v) begin
            errors++;
            $display("FAIL overflow a=%h b=%h sub=%b: got %b, required %b", ea, eb, esub, overflow, v);
        end
        checks++;
        if (zero !== z) begin
            errors++;
            $display("FAIL zero a=%h b=%h sub=%b: got %b, required %b", ea, eb, esub, zero, z);
        end
        hold_res = r; hold_c = c; hold_ov = v; hold_z = z;
    endtask

    // One cycle with no request; block must be idle and holding outputs
    task automatic idle_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== hold_res || cout !== hold_c ||
            overflow !== hold_ov || zero !== hold_z) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b result=%h c=%b v=%b z=%b, required 0 0 %h %b %b %b",
                     busy, done, result, cout, overflow, zero, hold_res, hold_c, hold_ov, hold_z);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (result !== '0 || cout !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: result=%h c=%b v=%b z=%b, required 0", result, cout, overflow, zero);
        end
        rst = 1'b0;
        hold_res = '0; hold_c = 1'b0; hold_ov = 1'b0; hold_z = 1'b0;
        idle_cycle();
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb[5] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
        logic         vs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            drive_start(va[k], vb[k], vs[k]);
            check_run(va[k], vb[k], vs[k], 0);
            if (k == 0) begin
                checks++;
                if (result !== 16'h2233) begin
                    errors++;
                    $display("FAIL first_vector: got %h, required 2233", result);
                end
            end
            idle_cycle();
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        drive_start(16'h0010, 16'h0001, 1'b0);
        check_run(16'h0010, 16'h0001, 1'b0, 2);
        checks++;
        if (result !== 16'h0011) begin
            errors++;
            $display("FAIL ignored_start: got %h, required 0011", result);
        end
        // Request in the DONE cycle is accepted back-to-back
        drive_start(16'h4321, 16'h1111, 1'b1);
        check_run(16'h4321, 16'h1111, 1'b1, 0);
        idle_cycle();
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            rs = 1'($urandom);
            drive_start(ra, rb, rs);
            check_run(ra, rb, rs, $urandom_range(0, NIBBLES));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_run();
        drive_start(16'h1357, 16'h2468, 1'b0);
        @(negedge clk);           // cycle 2
        rst = 1'b1;
        @(negedge clk);           // cycle 3
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 ||
            overflow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, cout, overflow, zero);
        end
        hold_res = '0; hold_c = 1'b0; hold_ov = 1'b0; hold_z = 1'b0;
        repeat (NIBBLES + 1) idle_cycle();
        drive_start(16'h7000, 16'h1000, 1'b0);
        check_run(16'h7000, 16'h1000, 1'b0, 0);
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
